reg_write_buffer: RTL and testbench
===================================

# reg_write_buffer

Small FIFO of pending register writes that sits directly upstream of the R0–R15 register file and owns its single write port. Producers (ALU result path, memory-load return) push address/data pairs with a valid/ready handshake. The buffer drains one entry per cycle into the register file's `reg_addr`/`enable`/`D` inputs. It also exposes a per-register pending scoreboard and a newest-match bypass lookup so operand fetch can see writes not yet committed.

## Interface
- `DEPTH`, 4, number of queued writes; power of two, ≥2
- `DATA_W`, 32, data width
- `ADDR_W`, 4, register address width (16 registers)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `clr_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer offers a write
- `in_ready`  out  1  buffer accepts; a push occurs when `in_valid && in_ready` at the edge
- `in_addr`  in  ADDR_W  target register
- `in_data`  in  DATA_W  write data
- `hold`  in  1  suppresses draining for this cycle (register file busy)
- `flush`  in  1  synchronous discard of all queued entries
- `wr_en`  out  1  to register file `enable`
- `wr_addr`  out  ADDR_W  to register file `reg_addr`
- `wr_data`  out  DATA_W  to register file `D`
- `lookup_addr`  in  ADDR_W  register being read by operand fetch
- `lookup_hit`  out  1  some queued entry targets `lookup_addr`
- `lookup_data`  out  DATA_W  data of the newest matching entry; 0 on miss
- `pending_mask`  out  16  bit i = 1 when any queued entry targets register i
- `count`  out  $clog2(DEPTH+1)  number of queued entries
- `empty`, `full`  out  1  `count == 0` and `count == DEPTH`, respectively

## Operation
- Storage is a circular buffer with head/tail pointers, an entry counter, and a valid bit per slot.
- **Push:** `in_valid && in_ready`. Writes the entry at the tail and advances the tail modulo `DEPTH`.
- **Pop:** `wr_en` is high. The head entry is written into the register file on the same edge, and the head advances modulo `DEPTH`.
- **Drain outputs:** `wr_en = !empty && !hold && !flush`. `wr_addr`/`wr_data` present the head entry when `wr_en` is high and are forced to 0 otherwise.
- **Accept condition:** `in_ready = !full && !flush`. There is no combinational path from `hold` or the pop condition, so a full buffer refuses a push even in a cycle where it pops.
- **Push and pop together:** `count` is unchanged; both pointers advance.
- **Flush:** has priority over push and pop. On the next edge, all valid bits clear, pointers go to 0, and `count` goes to 0.
- **Order:** entries drain in arrival order. Duplicate addresses are kept, never merged, so the last write wins in the register file.
- **Lookup:** combinational, over queued entries only (an entry pushed this cycle is not visible until the next cycle). Returns the newest match, scanning from tail−1 back toward head.
- **Scoreboard:** `pending_mask` is the OR of one-hot(addr) over valid entries.
- No address is special-cased; R0 writes are queued like any other register.

## Timing
- **Reset** (`clr_n` low, asynchronous): `count` = 0, pointers = 0, all valid bits = 0. Outputs: `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `in_ready` = 1, `empty` = 1, `full` = 0, `pending_mask` = 0, `lookup_hit` = 0, `lookup_data` = 0.
- **Reset mid-operation:** queued writes are lost. The register file's own clear covers architectural state.
- **Latency, empty buffer:** a push at edge N gives `wr_en` high during cycle N+1, and the register file is written at edge N+1.
- **Throughput:** one push and one pop per cycle.
- **Drain rate:** a full buffer with `hold` low drains `DEPTH` entries in `DEPTH` cycles.
- **Hold:** freezes the head. `wr_*` outputs read 0 while `hold` is high, and the entry reappears when `hold` drops.

## Structure
- Shared package `cpu_pkg` holds:
  - constants `NUM_REGS` = 16, `REG_ADDR_W` = 4, `DATA_W` = 32
  - typedef `wb_entry_t` {addr, data}
- One sub-module, `wb_match`: parameterised newest-first priority search over the entry array (valid, addr, data, head, count). Returns hit and data. It is reused later by operand-fetch bypass.

## Test plan
- **Reset, then single write:** push (addr 5, 0xDEADBEEF) at edge 1. Expect `wr_en` = 1, `wr_addr` = 5, `wr_data` = 0xDEADBEEF during cycle 2. `pending_mask` = 0x0020 during cycle 2 and 0x0000 after edge 2.
- **Fill with `hold` = 1:** push addrs 1, 2, 3, 4. Expect `full` = 1, `in_ready` = 0, `count` = 4, `pending_mask` = 0x001E. A fifth push is refused. Release `hold`: writes 1, 2, 3, 4 appear in 4 consecutive cycles.
- **Duplicate address:** queue (7, 0x11) then (7, 0x22) with `hold` = 1. `lookup_addr` = 7 gives `lookup_hit` = 1, `lookup_data` = 0x22. Drain order is 0x11 then 0x22.
- **Wrap-around with concurrent push/pop:** sustain a push and a pop every cycle for 10 cycles. Expect `count` constant at 1 and data order preserved across pointer wrap.
- **Flush with push asserted:** with 3 entries queued, assert `flush` together with `in_valid`. Expect `in_ready` = 0 and `wr_en` = 0 that cycle, `count` = 0 and `pending_mask` = 0 after the edge, and the offered entry not stored.
- **Async reset mid-drain:** assert `clr_n` low between edges while draining. Expect `wr_en` = 0 immediately, without waiting for a clock edge, and all outputs at their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register write-back entry type used by the
// write buffer and, later, by operand-fetch bypass.
package cpu_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Newest-first associative search over a circular queue of register writes.
// Slots are visited oldest to newest so the last hit overrides earlier ones.
module wb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic [CNT_W-1:0]             count_i,
  input  logic [ADDR_W-1:0]            key_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      // Pointer arithmetic wraps naturally because DEPTH is a power of two.
      idx = head_i + PTR_W'(k);
      if ((CNT_W'(k) < count_i) && valid_i[idx] && (addr_i[idx] == key_i)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// Pending register-write FIFO that owns the register file write port, with a
// per-register pending scoreboard and a newest-match bypass lookup.
module reg_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_addr,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          hold,
  input  logic                          flush,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  input  logic [ADDR_W-1:0]             lookup_addr,
  output logic                          lookup_hit,
  output logic [DATA_W-1:0]             lookup_data,
  output logic [cpu_pkg::NUM_REGS-1:0]  pending_mask,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]             vld_q,  vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]             head_q, head_d;
  logic [PTR_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             cnt_q,  cnt_d;
  logic                         push, pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign count    = cnt_q;

  // Readiness deliberately ignores hold/pop so in_ready never depends on
  // the register file's busy signal.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign wr_en    = !empty && !hold && !flush;
  assign pop      = wr_en;

  assign wr_addr  = wr_en ? addr_q[head_q] : '0;
  assign wr_data  = wr_en ? data_q[head_q] : '0;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      vld_d  = '0;
    end else begin
      if (pop) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + 1'b1;
      end
      if (push) begin
        vld_d[tail_q]  = 1'b1;
        addr_d[tail_q] = in_addr;
        data_d[tail_q] = in_data;
        tail_d         = tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pending_mask[addr_q[i]] = 1'b1;
  end

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .valid_i (vld_q),
    .addr_i  (addr_q),
    .data_i  (data_q),
    .head_i  (head_q),
    .count_i (cnt_q),
    .key_i   (lookup_addr),
    .hit_o   (lookup_hit),
    .data_o  (lookup_data)
  );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed bench for reg_write_buffer: vector table plus hand-written
// wrap, flush and asynchronous-reset sequences.
module tb_reg_write_buffer;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        in_valid, in_ready, hold, flush;
  logic [3:0]  in_addr, wr_addr, lookup_addr;
  logic [31:0] in_data, wr_data, lookup_data;
  logic        wr_en, lookup_hit, empty, full;
  logic [15:0] pending_mask;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_write_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(4)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .hold         (hold),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .pending_mask (pending_mask),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic [3:0]  lk;
    logic        e_wr_en;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    int          e_cnt;
    logic        e_rdy;
    logic [15:0] e_pend;
    logic        e_hit;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic vld, input logic [3:0] addr,
                              input logic [31:0] data, input logic hld,
                              input logic [3:0] lk, input logic e_wr_en,
                              input logic [3:0] e_addr, input logic [31:0] e_data,
                              input int e_cnt, input logic e_rdy,
                              input logic [15:0] e_pend, input logic e_hit,
                              input logic [31:0] e_ld);
    vec_t v;
    v.vld = vld; v.addr = addr; v.data = data; v.hold = hld; v.lk = lk;
    v.e_wr_en = e_wr_en; v.e_addr = e_addr; v.e_data = e_data;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_pend = e_pend;
    v.e_hit = e_hit; v.e_ld = e_ld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_en"},   32'(wr_en), 32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".wr_data"}, wr_data, 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".empty"},   32'(empty), 32'd1);
    chk({tag, ".full"},    32'(full), 32'd0);
    chk({tag, ".count"},   32'(count), 32'd0);
    chk({tag, ".pending"}, 32'(pending_mask), 32'd0);
    chk({tag, ".hit"},     32'(lookup_hit), 32'd0);
    chk({tag, ".ldata"},   lookup_data, 32'd0);
  endtask

  // Called at posedge+1; outputs are checked mid-cycle, then one edge passes.
  task automatic apply_vec(input int n, input vec_t v);
    string t;
    t = $sformatf("v%0d", n);
    in_valid = v.vld; in_addr = v.addr; in_data = v.data;
    hold = v.hold; flush = 1'b0; lookup_addr = v.lk;
    #1;
    chk({t, ".wr_en"},    32'(wr_en), 32'(v.e_wr_en));
    chk({t, ".wr_addr"},  32'(wr_addr), 32'(v.e_addr));
    chk({t, ".wr_data"},  wr_data, v.e_data);
    chk({t, ".count"},    32'(count), 32'(v.e_cnt));
    chk({t, ".in_ready"}, 32'(in_ready), 32'(v.e_rdy));
    chk({t, ".pending"},  32'(pending_mask), 32'(v.e_pend));
    chk({t, ".hit"},      32'(lookup_hit), 32'(v.e_hit));
    chk({t, ".ldata"},    lookup_data, v.e_ld);
    chk({t, ".empty"},    32'(empty), 32'(v.e_cnt == 0));
    chk({t, ".full"},     32'(full), 32'(v.e_cnt == 4));
    @(posedge clk); #1;
  endtask

  task automatic push_held(input logic [3:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d; hold = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // single write, fill under hold, duplicate address
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 5, 1, 5, 32'hDEADBEEF, 1, 1, 16'h0020, 1, 32'hDEADBEEF);
    tbl[2]  = mk(0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tbl[3]  = mk(1, 1, 32'h101, 1, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tbl[4]  = mk(1, 2, 32'h102, 1, 1, 0, 0, 0, 1, 1, 16'h0002, 1, 32'h101);
    tbl[5]  = mk(1, 3, 32'h103, 1, 2, 0, 0, 0, 2, 1, 16'h0006, 1, 32'h102);
    tbl[6]  = mk(1, 4, 32'h104, 1, 3, 0, 0, 0, 3, 1, 16'h000E, 1, 32'h103);
    tbl[7]  = mk(1, 5, 32'h105, 1, 4, 0, 0, 0, 4, 0, 16'h001E, 1, 32'h104);
    tbl[8]  = mk(0, 0, 0, 0, 5, 1, 1, 32'h101, 4, 0, 16'h001E, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1, 2, 32'h102, 3, 1, 16'h001C, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 4, 1, 3, 32'h103, 2, 1, 16'h0018, 1, 32'h104);
    tbl[11] = mk(0, 0, 0, 0, 4, 1, 4, 32'h104, 1, 1, 16'h0010, 1, 32'h104);
    tbl[12] = mk(0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tbl[13] = mk(1, 7, 32'h11, 1, 7, 0, 0, 0, 0, 1, 16'h0000, 0, 0);
    tbl[14] = mk(1, 7, 32'h22, 1, 7, 0, 0, 0, 1, 1, 16'h0080, 1, 32'h11);
    tbl[15] = mk(0, 0, 0, 1, 7, 0, 0, 0, 2, 1, 16'h0080, 1, 32'h22);
    tbl[16] = mk(0, 0, 0, 0, 7, 1, 7, 32'h11, 2, 1, 16'h0080, 1, 32'h22);
    tbl[17] = mk(0, 0, 0, 0, 7, 1, 7, 32'h22, 1, 1, 16'h0080, 1, 32'h22);
    tbl[18] = mk(0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 16'h0000, 0, 0);

    idle_inputs();
    lookup_addr = 4'd5;
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    clr_n = 1'b1;

    for (int i = 0; i < 19; i++) apply_vec(i, tbl[i]);

    // Concurrent push/pop every cycle, crossing the pointer wrap point.
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 11); in_addr = 4'(i + 3); in_data = 32'hA500_0000 + i;
      hold = 1'b0; flush = 1'b0;
      #1;
      if (i == 0) begin
        chk($sformatf("wrap%0d.wr_en", i), 32'(wr_en), 32'd0);
        chk($sformatf("wrap%0d.count", i), 32'(count), 32'd0);
      end else begin
        chk($sformatf("wrap%0d.wr_en", i),   32'(wr_en), 32'd1);
        chk($sformatf("wrap%0d.wr_addr", i), 32'(wr_addr), 32'((i + 2) % 16));
        chk($sformatf("wrap%0d.wr_data", i), wr_data, 32'hA500_0000 + 32'(i - 1));
        chk($sformatf("wrap%0d.count", i),   32'(count), 32'd1);
        chk($sformatf("wrap%0d.in_ready", i), 32'(in_ready), 32'd1);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    #1;
    chk("wrap_end.count", 32'(count), 32'd0);
    chk("wrap_end.wr_en", 32'(wr_en), 32'd0);
    @(posedge clk); #1;

    // Flush with a push offered in the same cycle.
    for (int j = 0; j < 3; j++) push_held(4'(10 + j), 32'hF0 + j);
    in_valid = 1'b1; in_addr = 4'd9; in_data = 32'hF1F1; hold = 1'b0; flush = 1'b1;
    lookup_addr = 4'd11;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    chk("flush.wr_en",    32'(wr_en), 32'd0);
    chk("flush.wr_addr",  32'(wr_addr), 32'd0);
    chk("flush.count",    32'(count), 32'd3);
    chk("flush.pending",  32'(pending_mask), 32'h1C00);
    chk("flush.hit",      32'(lookup_hit), 32'd1);
    chk("flush.ldata",    lookup_data, 32'hF1);
    @(posedge clk); #1;
    idle_inputs();
    lookup_addr = 4'd9;
    #1;
    chk("post_flush.count",   32'(count), 32'd0);
    chk("post_flush.pending", 32'(pending_mask), 32'd0);
    chk("post_flush.hit",     32'(lookup_hit), 32'd0);
    chk("post_flush.empty",   32'(empty), 32'd1);
    chk("post_flush.wr_en",   32'(wr_en), 32'd0);
    @(posedge clk); #1;
    chk("post_flush2.count", 32'(count), 32'd0);

    // Asynchronous reset while draining.
    for (int j = 0; j < 3; j++) push_held(4'(2 + j), 32'hC0 + j);
    idle_inputs();
    lookup_addr = 4'd3;
    #1;
    chk("drain.wr_en",   32'(wr_en), 32'd1);
    chk("drain.wr_addr", 32'(wr_addr), 32'd2);
    chk("drain.wr_data", wr_data, 32'hC0);
    chk("drain.count",   32'(count), 32'd3);
    #1;
    clr_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    clr_n = 1'b1;
    #1;
    chk("after_rst.count", 32'(count), 32'd0);
    @(posedge clk); #1;
    chk("after_rst2.wr_en", 32'(wr_en), 32'd0);
    chk("after_rst2.count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
